// File: rtl/xadac_vmacc_seq.sv
// xadac_vmacc_seq: multi-cycle vector multiply-accumulate slave on the xadac
// coprocessor port. Each sum lane i computes
//   vd[i] = vs2[i] + sum_{j<jlen} vs0[i,j] * vs1[i,j]
// LanesPerBeat sum lanes are updated per BUSY cycle.
//
// Handshakes: a transfer on any valid/ready pair happens on the rising clock
// edge where both valid and ready are high. The producer holds valid and its
// payload steady until that edge. exe_req_ready depends only on the FSM state,
// never on exe_req_valid. exe_rsp_* is driven from registers and held
// unchanged while exe_rsp_valid is high and exe_rsp_ready is low.
module xadac_vmacc_seq #(
  parameter int IdWidth      = 4,
  parameter int VecDataWidth = 64,
  parameter int VecElemWidth = 8,
  parameter int VecSumWidth  = 32,
  parameter int VecLenWidth  = 3,
  parameter int LanesPerBeat = 1
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      dec_req_valid,
  output logic                      dec_req_ready,
  input  logic [IdWidth-1:0]        dec_req_id,
  output logic                      dec_rsp_valid,
  input  logic                      dec_rsp_ready,
  output logic [IdWidth-1:0]        dec_rsp_id,
  output logic                      dec_rsp_accept,
  output logic                      dec_rsp_vd_clobber,
  output logic [2:0]                dec_rsp_vs_read,
  input  logic                      exe_req_valid,
  output logic                      exe_req_ready,
  input  logic [IdWidth-1:0]        exe_req_id,
  input  logic [31:0]               exe_req_instr,
  input  logic [3*VecDataWidth-1:0] exe_req_vs_data,
  output logic                      exe_rsp_valid,
  input  logic                      exe_rsp_ready,
  output logic [IdWidth-1:0]        exe_rsp_id,
  output logic [4:0]                exe_rsp_vd_addr,
  output logic [VecDataWidth-1:0]   exe_rsp_vd_data,
  output logic                      exe_rsp_vd_write
);

  localparam int NSUM   = VecDataWidth / VecSumWidth;
  localparam int NBEATS = NSUM / LanesPerBeat;
  localparam int EPL    = VecSumWidth / VecElemWidth;  // elements per sum lane
  localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int JW     = $clog2(EPL + 1);
  localparam int XW     = VecSumWidth + 8;             // widened lane sum
  localparam int PW     = 2 * VecElemWidth + 2;        // signed product width

  localparam logic signed [XW-1:0] SAT_HI = {9'h000, {(VecSumWidth-1){1'b1}}};
  localparam logic signed [XW-1:0] SAT_LO = {9'h1FF, {(VecSumWidth-1){1'b0}}};

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]               state;
  logic [BW-1:0]            beat;
  logic [IdWidth-1:0]       id_q;
  logic [4:0]               addr_q;
  logic [1:0]               mode_q;   // [0] signed vs1, [1] saturate
  logic [JW-1:0]            jlen_q;
  logic [VecDataWidth-1:0]  va_q;
  logic [VecDataWidth-1:0]  vb_q;
  logic [VecDataWidth-1:0]  acc;
  logic [VecDataWidth-1:0]  acc_next;
  logic [VecLenWidth-1:0]   len_field;
  logic [JW-1:0]            jlen_in;
  logic                     unused_instr;

  // Decode is a stateless pass-through that accepts every instruction.
  assign dec_rsp_valid      = dec_req_valid;
  assign dec_req_ready      = dec_req_valid & dec_rsp_ready;
  assign dec_rsp_id         = dec_req_id;
  assign dec_rsp_accept     = 1'b1;
  assign dec_rsp_vd_clobber = 1'b1;
  assign dec_rsp_vs_read    = 3'b111;

  assign exe_req_ready    = (state == S_IDLE);
  assign exe_rsp_valid    = (state == S_DONE);
  assign exe_rsp_vd_write = exe_rsp_valid;
  assign exe_rsp_id       = id_q;
  assign exe_rsp_vd_addr  = addr_q;
  assign exe_rsp_vd_data  = acc;

  // Only a few instruction fields matter; the rest is reduced here on purpose.
  assign unused_instr = ^exe_req_instr;
  assign len_field    = exe_req_instr[25 +: VecLenWidth];

  // Element count is clipped to the number of elements that fit in one lane.
  always_comb begin
    jlen_in = JW'(len_field);
    if (int'(len_field) > EPL) jlen_in = JW'(EPL);
  end

  // One sum lane: accumulate widened products, then wrap or saturate.
  function automatic logic [VecSumWidth-1:0] lane_mac(
    input logic [VecSumWidth-1:0] acc_l,
    input logic [VecSumWidth-1:0] a_l,
    input logic [VecSumWidth-1:0] b_l,
    input logic [JW-1:0]          jl,
    input logic [1:0]             md
  );
    logic signed [XW-1:0]           sum;
    logic signed [VecElemWidth:0]   ax;
    logic signed [VecElemWidth:0]   bx;
    logic signed [PW-1:0]           p;
    sum = XW'($signed(acc_l));
    for (int j = 0; j < EPL; j++) begin
      ax = {a_l[j*VecElemWidth + VecElemWidth-1], a_l[j*VecElemWidth +: VecElemWidth]};
      bx = {md[0] & b_l[j*VecElemWidth + VecElemWidth-1], b_l[j*VecElemWidth +: VecElemWidth]};
      p  = PW'(ax) * PW'(bx);
      if (j < int'(jl)) sum = sum + XW'(p);
    end
    if (md[1]) begin
      if (sum > SAT_HI) sum = SAT_HI;
      else if (sum < SAT_LO) sum = SAT_LO;
    end
    return sum[VecSumWidth-1:0];
  endfunction

  // Next accumulator value: only the lanes owned by the current beat change.
  always_comb begin
    int lane;
    acc_next = acc;
    lane     = 0;
    for (int k = 0; k < LanesPerBeat; k++) begin
      lane = int'(beat) * LanesPerBeat + k;
      acc_next[lane*VecSumWidth +: VecSumWidth] =
        lane_mac(acc[lane*VecSumWidth +: VecSumWidth],
                 va_q[lane*VecSumWidth +: VecSumWidth],
                 vb_q[lane*VecSumWidth +: VecSumWidth],
                 jlen_q, mode_q);
    end
  end

  // Execute FSM: capture in IDLE, one beat per cycle in BUSY, hold in DONE.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state  <= S_IDLE;
      beat   <= '0;
      id_q   <= '0;
      addr_q <= '0;
      mode_q <= '0;
      jlen_q <= '0;
      va_q   <= '0;
      vb_q   <= '0;
      acc    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (exe_req_valid) begin
            id_q   <= exe_req_id;
            addr_q <= exe_req_instr[11:7];
            mode_q <= exe_req_instr[13:12];
            jlen_q <= jlen_in;
            va_q   <= exe_req_vs_data[0 +: VecDataWidth];
            vb_q   <= exe_req_vs_data[VecDataWidth +: VecDataWidth];
            acc    <= exe_req_vs_data[2*VecDataWidth +: VecDataWidth];
            beat   <= '0;
            state  <= S_BUSY;
          end
        end
        S_BUSY: begin
          acc <= acc_next;
          if (beat == BW'(NBEATS - 1)) state <= S_DONE;
          else beat <= beat + BW'(1);
        end
        S_DONE: begin
          if (exe_rsp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xadac_vmacc_seq.sv
// Testbench for xadac_vmacc_seq: driver tasks push expected responses into a
// scoreboard queue; a negedge monitor pops and compares on each handshake.
module tb_xadac_vmacc_seq;

  localparam int IW     = 4;
  localparam int DW     = 64;
  localparam int NBEATS = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- main DUT (LanesPerBeat=1) ----------------
  logic          dec_req_valid, dec_req_ready, dec_rsp_valid, dec_rsp_ready;
  logic [IW-1:0] dec_req_id, dec_rsp_id;
  logic          dec_rsp_accept, dec_rsp_vd_clobber;
  logic [2:0]    dec_rsp_vs_read;
  logic          exe_req_valid, exe_req_ready;
  logic [IW-1:0] exe_req_id;
  logic [31:0]   exe_req_instr;
  logic [3*DW-1:0] exe_req_vs_data;
  logic          exe_rsp_valid, exe_rsp_ready, exe_rsp_vd_write;
  logic [IW-1:0] exe_rsp_id;
  logic [4:0]    exe_rsp_vd_addr;
  logic [DW-1:0] exe_rsp_vd_data;

  xadac_vmacc_seq dut (
    .clk(clk), .rstn(rstn),
    .dec_req_valid(dec_req_valid), .dec_req_ready(dec_req_ready), .dec_req_id(dec_req_id),
    .dec_rsp_valid(dec_rsp_valid), .dec_rsp_ready(dec_rsp_ready), .dec_rsp_id(dec_rsp_id),
    .dec_rsp_accept(dec_rsp_accept), .dec_rsp_vd_clobber(dec_rsp_vd_clobber),
    .dec_rsp_vs_read(dec_rsp_vs_read),
    .exe_req_valid(exe_req_valid), .exe_req_ready(exe_req_ready), .exe_req_id(exe_req_id),
    .exe_req_instr(exe_req_instr), .exe_req_vs_data(exe_req_vs_data),
    .exe_rsp_valid(exe_rsp_valid), .exe_rsp_ready(exe_rsp_ready), .exe_rsp_id(exe_rsp_id),
    .exe_rsp_vd_addr(exe_rsp_vd_addr), .exe_rsp_vd_data(exe_rsp_vd_data),
    .exe_rsp_vd_write(exe_rsp_vd_write)
  );

  // ---------------- second DUT (LanesPerBeat=2) ----------------
  logic          b_dec_req_ready, b_dec_rsp_valid, b_dec_rsp_accept, b_dec_rsp_vd_clobber;
  logic [IW-1:0] b_dec_rsp_id;
  logic [2:0]    b_dec_rsp_vs_read;
  logic          b_exe_req_valid, b_exe_req_ready;
  logic [IW-1:0] b_exe_req_id;
  logic [31:0]   b_exe_req_instr;
  logic [3*DW-1:0] b_exe_req_vs_data;
  logic          b_exe_rsp_valid, b_exe_rsp_vd_write;
  logic          b_exe_rsp_ready;
  logic [IW-1:0] b_exe_rsp_id;
  logic [4:0]    b_exe_rsp_vd_addr;
  logic [DW-1:0] b_exe_rsp_vd_data;

  xadac_vmacc_seq #(.LanesPerBeat(2)) dut_lpb2 (
    .clk(clk), .rstn(rstn),
    .dec_req_valid(1'b0), .dec_req_ready(b_dec_req_ready), .dec_req_id(4'h0),
    .dec_rsp_valid(b_dec_rsp_valid), .dec_rsp_ready(1'b0), .dec_rsp_id(b_dec_rsp_id),
    .dec_rsp_accept(b_dec_rsp_accept), .dec_rsp_vd_clobber(b_dec_rsp_vd_clobber),
    .dec_rsp_vs_read(b_dec_rsp_vs_read),
    .exe_req_valid(b_exe_req_valid), .exe_req_ready(b_exe_req_ready), .exe_req_id(b_exe_req_id),
    .exe_req_instr(b_exe_req_instr), .exe_req_vs_data(b_exe_req_vs_data),
    .exe_rsp_valid(b_exe_rsp_valid), .exe_rsp_ready(b_exe_rsp_ready), .exe_rsp_id(b_exe_rsp_id),
    .exe_rsp_vd_addr(b_exe_rsp_vd_addr), .exe_rsp_vd_data(b_exe_rsp_vd_data),
    .exe_rsp_vd_write(b_exe_rsp_vd_write)
  );

  // ---------------- scoreboard state ----------------
  logic [DW-1:0] exp_q[$];
  logic [IW-1:0] exp_id_q[$];
  logic [4:0]    exp_addr_q[$];
  int            acc_cyc_q[$];
  int            n_checks = 0;
  int            n_fail = 0;
  int            rdy_mode = 0;   // 0: always ready, 1: random, 2: held low

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: per-lane integer arithmetic straight from the MAC definition.
  function automatic logic [63:0] model(input logic [31:0] instr, input logic [3*DW-1:0] vs);
    logic [63:0] r;
    longint s, a, b;
    int len;
    len = int'(instr[27:25]);
    if (len > 4) len = 4;
    r = '0;
    for (int i = 0; i < 2; i++) begin
      s = longint'($signed(vs[128 + 32*i +: 32]));
      for (int j = 0; j < len; j++) begin
        a = longint'($signed(vs[32*i + 8*j +: 8]));
        if (instr[12]) b = longint'($signed(vs[64 + 32*i + 8*j +: 8]));
        else           b = longint'(vs[64 + 32*i + 8*j +: 8]);
        s = s + a * b;
      end
      if (instr[13]) begin
        if (s > 64'sd2147483647) s = 64'sd2147483647;
        if (s < -64'sd2147483648) s = -64'sd2147483648;
      end
      r[32*i +: 32] = s[31:0];
    end
    return r;
  endfunction

  function automatic logic [31:0] mk_instr(input int len, input int f3, input int vd);
    logic [31:0] r;
    r = $urandom;
    r[27:25] = 3'(len);
    r[14:12] = 3'(f3);
    r[11:7]  = 5'(vd);
    return r;
  endfunction

  function automatic logic [3*DW-1:0] rand_vs();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- driver tasks (called at posedge+2) ----------------
  task automatic send(input logic [IW-1:0] id, input logic [31:0] instr,
                      input logic [3*DW-1:0] vs, input logic [DW-1:0] exp, input bit expect_rsp);
    int n;
    n = 0;
    while (!exe_req_ready && n < 200) begin
      @(posedge clk); #2; n++;
    end
    chk("send_wait_ready", {63'd0, exe_req_ready}, 64'd1);
    exe_req_valid   = 1'b1;
    exe_req_id      = id;
    exe_req_instr   = instr;
    exe_req_vs_data = vs;
    @(posedge clk); #2;
    if (expect_rsp) begin
      exp_q.push_back(exp);
      exp_id_q.push_back(id);
      exp_addr_q.push_back(instr[11:7]);
      acc_cyc_q.push_back(cyc);
    end
    exe_req_valid   = 1'b0;
    exe_req_instr   = $urandom;
    exe_req_vs_data = rand_vs();
    chk("accepted_ready_low", {63'd0, exe_req_ready}, 64'd0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 500) begin
      @(posedge clk); #2; n++;
    end
    chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- response-ready driver ----------------
  initial begin
    exe_rsp_ready = 1'b1;
    forever begin
      @(posedge clk); #2;
      case (rdy_mode)
        0: exe_rsp_ready = 1'b1;
        1: exe_rsp_ready = 1'($urandom_range(0, 1));
        default: exe_rsp_ready = 1'b0;
      endcase
    end
  end

  // ---------------- monitor ----------------
  logic          prev_valid = 1'b0;
  logic          prev_ready = 1'b0;
  logic [DW-1:0] prev_data;
  logic [IW-1:0] prev_id;
  logic [4:0]    prev_addr;

  always @(negedge clk) begin
    if (rstn) begin
      if (prev_valid && !prev_ready) begin
        chk("hold_valid", {63'd0, exe_rsp_valid}, 64'd1);
        chk("hold_data", exe_rsp_vd_data, prev_data);
        chk("hold_id", 64'(exe_rsp_id), 64'(prev_id));
        chk("hold_addr", 64'(exe_rsp_vd_addr), 64'(prev_addr));
      end
      if (exe_rsp_valid) begin
        chk("req_ready_in_done", {63'd0, exe_req_ready}, 64'd0);
        chk("vd_write", {63'd0, exe_rsp_vd_write}, 64'd1);
        if (!prev_valid) begin
          if (acc_cyc_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_rsp: got valid with id %h expected no response", exe_rsp_id);
          end else begin
            chk("latency", 64'(cyc - acc_cyc_q[0]), 64'(NBEATS));
          end
        end
        if (exe_rsp_ready && exp_q.size() > 0) begin
          chk("rsp_data", exe_rsp_vd_data, exp_q.pop_front());
          chk("rsp_id", 64'(exe_rsp_id), 64'(exp_id_q.pop_front()));
          chk("rsp_addr", 64'(exe_rsp_vd_addr), 64'(exp_addr_q.pop_front()));
          void'(acc_cyc_q.pop_front());
        end
      end
    end
    prev_valid = exe_rsp_valid & rstn;
    prev_ready = exe_rsp_ready;
    prev_data  = exe_rsp_vd_data;
    prev_id    = exe_rsp_id;
    prev_addr  = exe_rsp_vd_addr;
  end

  // ---------------- stimulus ----------------
  localparam logic [63:0] ALL_FF = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] ALL_02 = 64'h0202_0202_0202_0202;
  localparam logic [63:0] ALL_7F = 64'h7F7F_7F7F_7F7F_7F7F;
  localparam logic [63:0] TEN2   = {32'd10, 32'd10};
  localparam logic [63:0] MAX2   = {32'h7FFF_FFFF, 32'h7FFF_FFFF};

  initial begin
    logic [3*DW-1:0] vs;
    logic [31:0]     ins;
    logic [DW-1:0]   e;
    dec_req_valid = 0; dec_req_id = 0; dec_rsp_ready = 0;
    exe_req_valid = 0; exe_req_id = 0; exe_req_instr = 0; exe_req_vs_data = '0;
    b_exe_req_valid = 0; b_exe_req_id = 0; b_exe_req_instr = 0; b_exe_req_vs_data = '0;
    b_exe_rsp_ready = 1'b1;

    // reset state
    repeat (3) @(posedge clk);
    #2;
    chk("rst_req_ready", {63'd0, exe_req_ready}, 64'd1);
    chk("rst_rsp_valid", {63'd0, exe_rsp_valid}, 64'd0);
    chk("rst_data", exe_rsp_vd_data, 64'd0);
    chk("rst_id", 64'(exe_rsp_id), 64'd0);
    chk("rst_addr", 64'(exe_rsp_vd_addr), 64'd0);
    rstn = 1'b1;

    // decode handshake
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #2;
      dec_req_valid = 1'($urandom_range(0, 1));
      dec_rsp_ready = 1'($urandom_range(0, 1));
      dec_req_id    = 4'($urandom);
      #1;
      chk("dec_rsp_valid", {63'd0, dec_rsp_valid}, {63'd0, dec_req_valid});
      chk("dec_req_ready", {63'd0, dec_req_ready}, {63'd0, dec_req_valid & dec_rsp_ready});
      chk("dec_rsp_id", 64'(dec_rsp_id), 64'(dec_req_id));
      chk("dec_consts", {59'd0, dec_rsp_accept, dec_rsp_vd_clobber, dec_rsp_vs_read},
          {59'd0, 1'b1, 1'b1, 3'b111});
    end
    @(posedge clk); #2;

    // directed arithmetic cases, always-ready sink
    rdy_mode = 0;
    send(4'h1, mk_instr(4, 0, 3),  {TEN2, ALL_02, ALL_FF}, {32'd2, 32'd2}, 1);
    send(4'h2, mk_instr(4, 1, 4),  {TEN2, ALL_FF, ALL_FF}, {32'd14, 32'd14}, 1);
    send(4'h3, mk_instr(4, 0, 5),  {TEN2, ALL_FF, ALL_FF}, {32'hFFFF_FC0E, 32'hFFFF_FC0E}, 1);
    send(4'h4, mk_instr(4, 2, 6),  {MAX2, ALL_7F, ALL_7F}, MAX2, 1);
    send(4'h5, mk_instr(4, 6, 7),  {MAX2, ALL_7F, ALL_7F}, MAX2, 1);
    send(4'h6, mk_instr(4, 0, 8),  {MAX2, ALL_7F, ALL_7F}, {32'h8000_FC03, 32'h8000_FC03}, 1);
    send(4'h7, mk_instr(7, 0, 9),  {TEN2, ALL_02, ALL_FF}, {32'd2, 32'd2}, 1);
    send(4'h8, mk_instr(4, 3, 10), {{32'h8000_0000, 32'h8000_0000}, ALL_02, ALL_FF},
         {32'h8000_0000, 32'h8000_0000}, 1);
    for (int i = 0; i < 4; i++) begin
      vs = rand_vs();
      send(4'($urandom), mk_instr(0, $urandom_range(0, 7), $urandom_range(0, 31)), vs, vs[191:128], 1);
    end
    drain();

    // random operands under random backpressure
    rdy_mode = 1;
    for (int i = 0; i < 40; i++) begin
      vs  = rand_vs();
      ins = mk_instr($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 31));
      send(4'($urandom), ins, vs, model(ins, vs), 1);
    end
    drain();

    // stall in DONE with a competing request that must be ignored
    rdy_mode = 2;
    @(posedge clk); #2;
    vs  = rand_vs();
    ins = mk_instr(3, 1, 17);
    send(4'hA, ins, vs, model(ins, vs), 1);
    begin
      int n;
      n = 0;
      while (!exe_rsp_valid && n < 50) begin @(posedge clk); #2; n++; end
      chk("stall_reached_done", {63'd0, exe_rsp_valid}, 64'd1);
    end
    exe_req_valid   = 1'b1;
    exe_req_id      = 4'h5;
    exe_req_instr   = mk_instr(4, 0, 30);
    exe_req_vs_data = rand_vs();
    repeat (5) begin @(posedge clk); #2; end
    exe_req_valid = 1'b0;
    rdy_mode = 0;
    drain();

    // reset in the middle of BUSY drops the operation
    @(posedge clk); #2;
    vs = rand_vs();
    send(4'hC, mk_instr(4, 0, 12), vs, '0, 0);
    rstn = 1'b0;
    @(posedge clk); #2;
    rstn = 1'b1;
    chk("midrst_req_ready", {63'd0, exe_req_ready}, 64'd1);
    chk("midrst_rsp_valid", {63'd0, exe_rsp_valid}, 64'd0);
    chk("midrst_data", exe_rsp_vd_data, 64'd0);
    chk("midrst_id", 64'(exe_rsp_id), 64'd0);
    repeat (6) begin @(posedge clk); #2; end
    vs  = rand_vs();
    ins = mk_instr(2, 2, 21);
    send(4'hD, ins, vs, model(ins, vs), 1);
    drain();

    // LanesPerBeat=2 instance: one-cycle latency
    for (int i = 0; i < 4; i++) begin
      if (i == 0) begin
        vs = {TEN2, ALL_02, ALL_FF}; ins = mk_instr(4, 0, 2);
      end else begin
        vs = rand_vs(); ins = mk_instr($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 31));
      end
      e = model(ins, vs);
      chk("lpb2_idle_ready", {63'd0, b_exe_req_ready}, 64'd1);
      b_exe_req_valid   = 1'b1;
      b_exe_req_id      = 4'(i + 3);
      b_exe_req_instr   = ins;
      b_exe_req_vs_data = vs;
      @(posedge clk); #2;
      b_exe_req_valid = 1'b0;
      chk("lpb2_busy_valid", {63'd0, b_exe_rsp_valid}, 64'd0);
      @(posedge clk); #2;
      chk("lpb2_valid_lat1", {63'd0, b_exe_rsp_valid}, 64'd1);
      chk("lpb2_data", b_exe_rsp_vd_data, e);
      chk("lpb2_id", 64'(b_exe_rsp_id), 64'(i + 3));
      chk("lpb2_addr", 64'(b_exe_rsp_vd_addr), 64'(ins[11:7]));
      @(posedge clk); #2;
      chk("lpb2_back_idle", {63'd0, b_exe_rsp_valid}, 64'd0);
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
